// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
//
// Purpose:
//   Registered downstream stage for the 4-bit ripple/CLA adders. Operand
//   beats are added, with their carry-in, into a running WIDTH-bit
//   accumulator. After BURST beats the block presents the burst total as a
//   residue plus a count of carry-outs:
//   total = out_carries * 2^WIDTH + out_sum.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clear        synchronous abort, returns the block to IDLE
//   in_valid     operand beat valid
//   in_ready     block can accept a beat (registered)
//   in_data      operand, WIDTH bits
//   in_cin       carry-in added together with in_data
//   out_valid    result valid (registered)
//   out_ready    consumer accepts the result
//   out_sum      accumulator residue mod 2^WIDTH
//   out_carries  carry-outs seen this burst, saturating at 255
// ---------------------------------------------------------------------------
module sum_accumulator #(
    parameter int WIDTH = 4,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [7:0]       out_carries
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wide enough for the largest legal burst length.
    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [7:0]       carries_q, carries_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             beat;
    logic [WIDTH-1:0] acc_base;
    logic [7:0]       carries_base;
    logic [7:0]       carries_inc;
    logic [WIDTH:0]   sum_ext;

    // A burst always starts from zero, so the first beat taken in IDLE
    // ignores whatever the accumulator holds.
    always_comb begin
        beat         = in_valid & in_ready_q;
        acc_base     = (state_q == IDLE) ? '0 : acc_q;
        carries_base = (state_q == IDLE) ? 8'd0 : carries_q;
        sum_ext      = {1'b0, acc_base} + {1'b0, in_data} + {{WIDTH{1'b0}}, in_cin};
        carries_inc  = (carries_base == 8'hFF) ? 8'hFF : carries_base + 8'd1;
    end

    // Next-state logic. clear outranks both handshakes and drops any beat
    // presented in the same cycle. in_ready/out_valid are computed one
    // cycle ahead so both leave the block straight from flops.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        carries_d   = carries_q;
        beat_cnt_d  = beat_cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        if (clear) begin
            state_d     = IDLE;
            acc_d       = '0;
            carries_d   = 8'd0;
            beat_cnt_d  = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_d = 1'b1;
                    if (beat) begin
                        acc_d      = sum_ext[WIDTH-1:0];
                        carries_d  = sum_ext[WIDTH] ? carries_inc : carries_base;
                        beat_cnt_d = CNT_W'(1);
                        if (BURST == 1) begin
                            state_d     = DONE;
                            in_ready_d  = 1'b0;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = ACC;
                        end
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc_d      = sum_ext[WIDTH-1:0];
                        carries_d  = sum_ext[WIDTH] ? carries_inc : carries_base;
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        if (beat_cnt_q == LAST_CNT) begin
                            state_d     = DONE;
                            in_ready_d  = 1'b0;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d     = IDLE;
                        acc_d       = '0;
                        carries_d   = 8'd0;
                        beat_cnt_d  = '0;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    acc_d       = '0;
                    carries_d   = 8'd0;
                    beat_cnt_d  = '0;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // in_ready stays low for the whole reset and rises on the first edge
    // after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            carries_q   <= 8'd0;
            beat_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carries_q   <= carries_d;
            beat_cnt_q  <= beat_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_sum     = acc_q;
    assign out_carries = carries_q;

endmodule
